// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - fetch PC owner, imem req/ack master and instruction queue
module instruction_fetch_queue #(
  parameter int ADDRESS_LEN     = 12,
  parameter int INSTRUCTION_LEN = 19,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [ADDRESS_LEN-1:0]     redirect_pc,
  input  logic                       deq,
  output logic                       out_valid,
  output logic [INSTRUCTION_LEN-1:0] out_instruction,
  output logic [ADDRESS_LEN-1:0]     out_pc_plus1,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INSTRUCTION_LEN + ADDRESS_LEN;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_LEN-1:0] pending_q, pending_d;
  logic                   req_q, req_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     head;
  logic                   push;
  logic                   pop;
  logic                   head_valid;
  logic [CNT_W-1:0]       count_after;

  assign head_valid = (count_q != '0);
  assign head       = mem[rd_ptr_q];

  // Head entry is decoded from registered storage only; nothing from imem reaches out_*
  always_comb begin
    out_valid       = head_valid;
    out_instruction = '0;
    out_pc_plus1    = '0;
    if (head_valid) begin
      out_instruction = head[ENTRY_W-1:ADDRESS_LEN];
      out_pc_plus1    = head[ADDRESS_LEN-1:0];
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign count     = count_q;

  // Next-state for fetch FSM, pointers and occupancy; redirect overrides everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Only a WAIT-state ack carries live data; a DISCARD ack is the cancelled fetch
    push = (state_q == WAIT) && imem_ack && !redirect;
    pop  = deq && head_valid && !redirect;
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          addr_d  = redirect_pc;
        end
        WAIT: begin
          if (imem_ack) begin
            state_d = WAIT;
            addr_d  = redirect_pc;
          end else begin
            // Request cannot be withdrawn: keep it up and remember where to go next
            state_d   = DISCARD;
            pending_d = redirect_pc;
          end
        end
        DISCARD: begin
          pending_d = redirect_pc;
          if (imem_ack) begin
            state_d = WAIT;
            addr_d  = redirect_pc;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      count_d  = count_after;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      case (state_q)
        IDLE: begin
          if (count_after < CNT_W'(DEPTH)) begin
            state_d = WAIT;
            addr_d  = fetch_pc_q;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_LEN'(1);
            if (count_after < CNT_W'(DEPTH)) begin
              addr_d = fetch_pc_q + ADDRESS_LEN'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state_d    = WAIT;
            addr_d     = pending_q;
            fetch_pc_d = pending_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d = (state_d != IDLE);
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      pending_q  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage: entry is {instruction, fetch address + 1}; validity comes from count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {imem_rdata, addr_q + ADDRESS_LEN'(1)};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed vector bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [18:0] out_instruction;
  logic [11:0] out_pc_plus1;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [2:0]  count;

  int applied = 0;
  int miscompares = 0;

  instruction_fetch_queue #(
    .ADDRESS_LEN(12),
    .INSTRUCTION_LEN(19),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .deq(deq),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc_plus1(out_pc_plus1),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] tag(input logic [11:0] a);
    return {7'h55, a};
  endfunction

  // memory returns an address-tagged word so every entry identifies its source address
  assign imem_rdata = tag(imem_addr);

  typedef struct {
    logic        redirect;
    logic [11:0] rpc;
    logic        deq;
    logic        ack;
    logic        e_valid;
    logic [11:0] e_head;
    logic [11:0] e_pc;
    logic        e_req;
    logic [11:0] e_addr;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [11:0] rpc, input logic d, input logic a,
                              input logic ev, input logic [11:0] eh, input logic [11:0] ep,
                              input logic er, input logic [11:0] ea, input logic [2:0] ec);
    vec_t v;
    v.redirect = r; v.rpc = rpc; v.deq = d; v.ack = a;
    v.e_valid = ev; v.e_head = eh; v.e_pc = ep; v.e_req = er; v.e_addr = ea; v.e_count = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic check_all(input int idx, input logic ev, input logic [11:0] eh, input logic [11:0] ep,
                           input logic er, input logic [11:0] ea, input logic [2:0] ec);
    logic [18:0] ei;
    ei = ev ? tag(eh) : 19'h0;
    applied++;
    chk("out_valid", idx, 32'(out_valid), 32'(ev));
    chk("out_instruction", idx, 32'(out_instruction), 32'(ei));
    chk("out_pc_plus1", idx, 32'(out_pc_plus1), 32'(ev ? ep : 12'h0));
    chk("imem_req", idx, 32'(imem_req), 32'(er));
    if (er) chk("imem_addr", idx, 32'(imem_addr), 32'(ea));
    chk("count", idx, 32'(count), 32'(ec));
  endtask

  initial begin
    // zero-wait streaming with deq=1
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h000, 1, 12'h000, 3'd0));
    vecs.push_back(mk(0, 12'h000, 1, 1, 1, 12'h000, 12'h001, 1, 12'h001, 3'd1));
    vecs.push_back(mk(0, 12'h000, 1, 1, 1, 12'h001, 12'h002, 1, 12'h002, 3'd1));
    vecs.push_back(mk(0, 12'h000, 1, 1, 1, 12'h002, 12'h003, 1, 12'h003, 3'd1));
    // fill with deq=0 until full, then request stops
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h002, 12'h003, 1, 12'h004, 3'd2));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h002, 12'h003, 1, 12'h005, 3'd3));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h002, 12'h003, 0, 12'h000, 3'd4));
    vecs.push_back(mk(0, 12'h000, 0, 0, 1, 12'h002, 12'h003, 0, 12'h000, 3'd4));
    // single deq lets exactly one more fetch through
    vecs.push_back(mk(0, 12'h000, 1, 0, 1, 12'h003, 12'h004, 1, 12'h006, 3'd3));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h003, 12'h004, 0, 12'h000, 3'd4));
    // redirect from IDLE with a full queue
    vecs.push_back(mk(1, 12'h0AB, 1, 0, 0, 12'h000, 12'h000, 1, 12'h0AB, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h0AB, 12'h0AC, 1, 12'h0AC, 3'd1));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h0AB, 12'h0AC, 1, 12'h0AD, 3'd2));
    // redirect + ack + deq with two entries queued
    vecs.push_back(mk(1, 12'h120, 1, 1, 0, 12'h000, 12'h000, 1, 12'h120, 3'd0));
    // 3-cycle latency: address stable until ack
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h000, 1, 12'h120, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 0, 0, 12'h000, 12'h000, 1, 12'h120, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h120, 12'h121, 1, 12'h121, 3'd1));
    // redirect while waiting: cancelled fetch stays on the bus, newest target wins
    vecs.push_back(mk(1, 12'h300, 0, 0, 0, 12'h000, 12'h000, 1, 12'h121, 3'd0));
    vecs.push_back(mk(1, 12'h340, 0, 0, 0, 12'h000, 12'h000, 1, 12'h121, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 0, 12'h000, 12'h000, 1, 12'h340, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h340, 12'h341, 1, 12'h341, 3'd1));
    // address wrap
    vecs.push_back(mk(1, 12'hFFE, 1, 1, 0, 12'h000, 12'h000, 1, 12'hFFE, 3'd0));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'hFFE, 12'hFFF, 1, 12'hFFF, 3'd1));
    vecs.push_back(mk(0, 12'h000, 1, 1, 1, 12'hFFF, 12'h000, 1, 12'h000, 3'd1));
    vecs.push_back(mk(0, 12'h000, 1, 1, 1, 12'h000, 12'h001, 1, 12'h001, 3'd1));
    // build up to three entries while waiting
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h000, 12'h001, 1, 12'h002, 3'd2));
    vecs.push_back(mk(0, 12'h000, 0, 1, 1, 12'h000, 12'h001, 1, 12'h003, 3'd3));

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 0, 12'h000, 12'h000, 0, 12'h000, 3'd0);
    chk("reset_imem_addr", -1, 32'(imem_addr), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      deq         = vecs[i].deq;
      imem_ack    = vecs[i].ack;
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_valid, vecs[i].e_head, vecs[i].e_pc,
                vecs[i].e_req, vecs[i].e_addr, vecs[i].e_count);
    end

    // asynchronous reset mid-WAIT with three entries: outputs clear without a clock edge
    redirect = 1'b0; deq = 1'b0; imem_ack = 1'b1;
    rst = 1'b1;
    #1;
    check_all(100, 0, 12'h000, 12'h000, 0, 12'h000, 3'd0);
    chk("async_reset_imem_addr", 100, 32'(imem_addr), 32'h0);
    @(posedge clk);
    #1;
    check_all(101, 0, 12'h000, 12'h000, 0, 12'h000, 3'd0);
    rst = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    #1;
    check_all(102, 0, 12'h000, 12'h000, 1, 12'h000, 3'd0);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    check_all(103, 1, 12'h000, 12'h001, 1, 12'h001, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Upstream neighbour of the IF/ID pipeline register: owns the fetch PC, issues requests to a variable-latency instruction memory over a req/ack handshake, and buffers fetched instructions with their PC+1 in a small FIFO. The decode stage pops one entry per cycle when it is not stalled. A redirect (branch, jump, return, flush) empties the queue, cancels any in-flight fetch and restarts fetching at a new target. Fetch thereby decouples from memory latency and decode stalls.

## Interface
Parameters:
- ADDRESS_LEN, 12, width of PC and memory address
- INSTRUCTION_LEN, 19, instruction width
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  ADDRESS_LEN  new fetch target, valid when redirect=1
- deq  in  1  decode consumes head entry this cycle (IF/ID write enable)
- out_valid  out  1  head entry valid
- out_instruction  out  INSTRUCTION_LEN  head instruction; 0 when empty
- out_pc_plus1  out  ADDRESS_LEN  head's fetch address + 1; 0 when empty
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDRESS_LEN  fetch address, registered, stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1
- imem_rdata  in  INSTRUCTION_LEN  fetched instruction
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- Reset: state IDLE, fetch_pc=0, queue empty, count=0, imem_req=0, imem_addr=0, out_valid=0, out_instruction=0, out_pc_plus1=0.
- Queue: circular buffer, read/write pointers wrap modulo DEPTH. Entry = {instruction, fetch_addr+1}. Push on accepted ack; pop when deq & out_valid. deq while empty is ignored. Push and pop in same cycle leave count unchanged and are legal when full (pop frees the slot first).
- Handshake: once imem_req rises it stays high with unchanged imem_addr until ack is sampled. The block never withdraws a request.
- States:
  - IDLE: imem_req=0. Go WAIT with imem_addr=fetch_pc when count_next < DEPTH.
  - WAIT: imem_req=1. On ack: push entry, fetch_pc++. Stay WAIT with imem_addr=fetch_pc+1 if count_next < DEPTH; else go IDLE.
  - DISCARD: imem_req=1 on the cancelled address. On ack: drop data, go WAIT at pending target.
- Redirect, highest priority; wins over same-cycle push and pop:
  - Queue cleared and count=0; fetch_pc=redirect_pc.
  - IDLE: next WAIT, imem_addr=redirect_pc.
  - WAIT with ack: returned data dropped; next WAIT, imem_addr=redirect_pc.
  - WAIT without ack: next DISCARD; target held in pending register.
  - DISCARD: pending target overwritten with the newest redirect_pc.
- PC arithmetic: fetch_pc+1 and stored pc_plus1 wrap modulo 2^ADDRESS_LEN (0xFFF -> 0x000).
- Reset asserted mid-operation returns everything to reset values immediately. Any outstanding memory response after reset is ignored because imem_req=0.

## Timing
- Request issue: one cycle from entering WAIT. After reset release, imem_req=1 with addr 0 in the cycle after the first edge.
- Fill latency: ack sampled at edge k -> out_valid=1 with that entry in cycle k+1.
- Throughput: one instruction per cycle with a memory acking in the same cycle as the request.
- Redirect sampled at edge k with no in-flight cancel -> out_valid=0 in cycle k+1; imem_req=1 with addr=redirect_pc in cycle k+1.
- Redirect with a cancel: first valid fetch from the target is requested the cycle after the cancelled ack.
- Outputs are registered or decoded from registered head; no combinational path from imem_ack/imem_rdata to out_*.

## Test plan
- Zero-wait memory (ack=req, rdata=addr-tagged), deq=1: entries from addr 0,1,2... appear one per cycle; pc_plus1 = 1,2,3; out_valid continuous from the second cycle after reset.
- deq=0 with DEPTH=4: exactly 4 entries fill; imem_req drops to 0; count=4. Then one deq: exactly one new request issued, count returns to 4.
- Memory with 3-cycle ack latency: imem_addr is stable for all 3 req cycles. Redirect to 0x120 in cycle 1 of the wait: cancelled data is never output; next request addr=0x120; first entry has pc_plus1=0x121.
- Same-cycle redirect, ack and deq with queue holding 2 entries: count=0 next cycle, out_valid=0, next imem_addr=redirect_pc.
- Fetch from 0xFFE, 0xFFF: pc_plus1 0xFFF then 0x000; next fetch addr 0x000.
- Assert rst during WAIT with count=3: all outputs 0 immediately. After release, fetch restarts at addr 0.
